board_referee: RTL and testbench

BOARD_REFEREE -- requirements
Module: board_referee

---
 rtl/board_referee.sv | 220 ++++++++++++++++++++++
 tb/tb_board_referee.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_referee.sv
// board_referee: tic-tac-toe move referee.
// Accepts one move request per submit assertion, checks it against the board
// and the side to move, answers with a single-cycle ack or nack, then scores
// the board for a win or draw and hands the turn over.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   update_loc        target cell 0..8, row-major
//   update_val        mark being placed (01 X, 10 O)
//   submit            move request level, held until ack/nack
//   new_game          synchronous restart, overrides everything else
//   board_state       packed board, cell i at [CELL_W*i +: CELL_W]
//   turn              side allowed to move (0 X, 1 O)
//   ack, nack         one-cycle accept / reject pulses
//   game_over         set once a win or draw is decided
//   winner            00 none, 01 X, 10 O, 11 draw
//   move_count        accepted moves in the current game, 0..9
module board_referee #(
  parameter int FIRST_TURN = 0,
  parameter int CELL_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            update_loc,
  input  logic [CELL_W-1:0]     update_val,
  input  logic                  submit,
  input  logic                  new_game,
  output logic [9*CELL_W-1:0]   board_state,
  output logic                  turn,
  output logic                  ack,
  output logic                  nack,
  output logic                  game_over,
  output logic [1:0]            winner,
  output logic [3:0]            move_count
);

  typedef enum logic [2:0] {
    IDLE,
    RESP,
    EVAL,
    WAIT_REL,
    OVER
  } state_t;

  localparam logic              TURN_INIT = (FIRST_TURN != 0);
  localparam logic [CELL_W-1:0] MARK_X    = CELL_W'(1);
  localparam logic [CELL_W-1:0] MARK_O    = CELL_W'(2);

  state_t            state_q, state_d;
  logic [CELL_W-1:0] cell_q [9];
  logic [CELL_W-1:0] cell_d [9];
  logic              turn_q, turn_d;
  logic              ack_q, ack_d;
  logic              nack_q, nack_d;
  logic              game_over_q, game_over_d;
  logic [1:0]        winner_q, winner_d;
  logic [3:0]        move_count_q, move_count_d;
  logic [3:0]        loc_q, loc_d;
  logic [CELL_W-1:0] val_q, val_d;
  logic              accepted_q, accepted_d;
  // In OVER, remembers that the current submit assertion was already answered
  logic              hold_q, hold_d;

  logic [CELL_W-1:0] cur_cell;
  logic              legal;
  logic [1:0]        win_mark;

  // Mark shared by a full line of three, or 00 if the line is not complete.
  function automatic logic [1:0] line_mark(input logic [CELL_W-1:0] a,
                                           input logic [CELL_W-1:0] b,
                                           input logic [CELL_W-1:0] c);
    return (a != '0 && a == b && a == c) ? 2'(a) : 2'b00;
  endfunction

  // Legality of the latched request, judged against the current board.
  always_comb begin
    cur_cell = '0;
    for (int i = 0; i < 9; i++) begin
      if (loc_q == 4'(i)) cur_cell = cell_q[i];
    end
    legal = (loc_q <= 4'd8) && (cur_cell == '0) &&
            (val_q == (turn_q ? MARK_O : MARK_X)) && !game_over_q;
  end

  // Only one side can ever complete lines in a legal game, so OR-ing the
  // eight line results yields that side's mark.
  always_comb begin
    win_mark = line_mark(cell_q[0], cell_q[1], cell_q[2]) |
               line_mark(cell_q[3], cell_q[4], cell_q[5]) |
               line_mark(cell_q[6], cell_q[7], cell_q[8]) |
               line_mark(cell_q[0], cell_q[3], cell_q[6]) |
               line_mark(cell_q[1], cell_q[4], cell_q[7]) |
               line_mark(cell_q[2], cell_q[5], cell_q[8]) |
               line_mark(cell_q[0], cell_q[4], cell_q[8]) |
               line_mark(cell_q[2], cell_q[4], cell_q[6]);
  end

  // Next-state and output logic; new_game overrides any state including an
  // in-flight request, which is then dropped without a response.
  always_comb begin
    state_d      = state_q;
    cell_d       = cell_q;
    turn_d       = turn_q;
    ack_d        = 1'b0;
    nack_d       = 1'b0;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    move_count_d = move_count_q;
    loc_d        = loc_q;
    val_d        = val_q;
    accepted_d   = accepted_q;
    hold_d       = hold_q;

    if (new_game) begin
      for (int i = 0; i < 9; i++) cell_d[i] = '0;
      turn_d       = TURN_INIT;
      game_over_d  = 1'b0;
      winner_d     = 2'b00;
      move_count_d = 4'd0;
      accepted_d   = 1'b0;
      hold_d       = 1'b0;
      state_d      = submit ? WAIT_REL : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (submit) begin
            loc_d   = update_loc;
            val_d   = update_val;
            state_d = RESP;
          end
        end
        RESP: begin
          if (legal) begin
            for (int i = 0; i < 9; i++) begin
              if (loc_q == 4'(i)) cell_d[i] = val_q;
            end
            move_count_d = (move_count_q == 4'd9) ? 4'd9 : move_count_q + 4'd1;
            ack_d        = 1'b1;
            accepted_d   = 1'b1;
          end else begin
            nack_d     = 1'b1;
            accepted_d = 1'b0;
          end
          state_d = EVAL;
        end
        EVAL: begin
          if (win_mark != 2'b00) begin
            winner_d    = win_mark;
            game_over_d = 1'b1;
            hold_d      = 1'b1;
            state_d     = OVER;
          end else if (move_count_q == 4'd9) begin
            winner_d    = 2'b11;
            game_over_d = 1'b1;
            hold_d      = 1'b1;
            state_d     = OVER;
          end else begin
            if (accepted_q) turn_d = ~turn_q;
            state_d = WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!submit) state_d = IDLE;
        end
        OVER: begin
          if (!submit) begin
            hold_d = 1'b0;
          end else if (!hold_q) begin
            nack_d = 1'b1;
            hold_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; reset clears the game without needing a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < 9; i++) cell_q[i] <= '0;
      turn_q       <= TURN_INIT;
      ack_q        <= 1'b0;
      nack_q       <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
      move_count_q <= 4'd0;
      loc_q        <= 4'd0;
      val_q        <= '0;
      accepted_q   <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < 9; i++) cell_q[i] <= cell_d[i];
      turn_q       <= turn_d;
      ack_q        <= ack_d;
      nack_q       <= nack_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      move_count_q <= move_count_d;
      loc_q        <= loc_d;
      val_q        <= val_d;
      accepted_q   <= accepted_d;
      hold_q       <= hold_d;
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_board
    assign board_state[CELL_W*g +: CELL_W] = cell_q[g];
  end

  assign turn       = turn_q;
  assign ack        = ack_q;
  assign nack       = nack_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign move_count = move_count_q;

endmodule

// File: tb/tb_board_referee.sv
// tb_board_referee: self-checking bench for board_referee.
// A game model built from the rules of tic-tac-toe predicts each response;
// predictions are queued when a request is driven and a monitor pops and
// compares them whenever the referee pulses ack or nack.
module tb_board_referee;

  localparam int FIRST_TURN = 0;
  localparam int CELL_W     = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          update_loc;
  logic [CELL_W-1:0]   update_val;
  logic                submit;
  logic                new_game;
  logic [9*CELL_W-1:0] board_state;
  logic                turn;
  logic                ack;
  logic                nack;
  logic                game_over;
  logic [1:0]          winner;
  logic [3:0]          move_count;

  board_referee #(
    .FIRST_TURN(FIRST_TURN),
    .CELL_W    (CELL_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .update_loc (update_loc),
    .update_val (update_val),
    .submit     (submit),
    .new_game   (new_game),
    .board_state(board_state),
    .turn       (turn),
    .ack        (ack),
    .nack       (nack),
    .game_over  (game_over),
    .winner     (winner),
    .move_count (move_count)
  );

  // Free-running clock: rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  typedef struct {
    bit is_ack;
    int board;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Game model state
  int m_board [9];
  int m_turn;
  bit m_over;
  int m_winner;
  int m_count;

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic int model_board_packed();
    int p = 0;
    for (int i = 0; i < 9; i++) p = p | (m_board[i] << (CELL_W * i));
    return p;
  endfunction

  function automatic int model_line_winner();
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int l = 0; l < 8; l++) begin
      if (m_board[lines[l][0]] != 0 &&
          m_board[lines[l][0]] == m_board[lines[l][1]] &&
          m_board[lines[l][0]] == m_board[lines[l][2]])
        return m_board[lines[l][0]];
    end
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    m_turn   = FIRST_TURN;
    m_over   = 1'b0;
    m_winner = 0;
    m_count  = 0;
  endfunction

  // Judge a request, apply it to the model board and queue the response.
  function automatic bit model_request(input int loc, input int val);
    bit legal = 1'b0;
    if (!m_over && loc >= 0 && loc <= 8 && val == (m_turn != 0 ? 2 : 1))
      legal = (m_board[loc] == 0);
    if (legal) begin
      m_board[loc] = val;
      if (m_count < 9) m_count++;
    end
    exp_q.push_back('{legal, model_board_packed(), m_count});
    return legal;
  endfunction

  // Score the board after an accepted move.
  function automatic void model_settle(input bit legal);
    int w;
    if (!legal) return;
    w = model_line_winner();
    if (w != 0) begin
      m_over   = 1'b1;
      m_winner = w;
    end else if (m_count == 9) begin
      m_over   = 1'b1;
      m_winner = 3;
    end else begin
      m_turn = 1 - m_turn;
    end
  endfunction

  // Wait (bounded) for ack/nack; scramble the request inputs while waiting,
  // the referee must use the values captured on the sampling edge.
  task automatic wait_response(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ack || nack) begin
        got = 1'b1;
      end else begin
        update_loc = 4'($urandom_range(0, 15));
        update_val = 2'($urandom_range(0, 3));
      end
    end
    if (!got) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s: no ack/nack within 20 cycles", name);
    end
  endtask

  task automatic checkOutput(input string tag);
    check_val({tag, ":board"},      int'(board_state), model_board_packed());
    check_val({tag, ":turn"},       int'(turn),        m_turn);
    check_val({tag, ":game_over"},  int'(game_over),   int'(m_over));
    check_val({tag, ":winner"},     int'(winner),      m_winner);
    check_val({tag, ":move_count"}, int'(move_count),  m_count);
  endtask

  task automatic checkResetValues(input string tag);
    check_val({tag, ":board"},      int'(board_state), 0);
    check_val({tag, ":turn"},       int'(turn),        FIRST_TURN);
    check_val({tag, ":ack"},        int'(ack),         0);
    check_val({tag, ":nack"},       int'(nack),        0);
    check_val({tag, ":game_over"},  int'(game_over),   0);
    check_val({tag, ":winner"},     int'(winner),      0);
    check_val({tag, ":move_count"}, int'(move_count),  0);
  endtask

  // One complete request: raise submit, await the answer, release, settle.
  task automatic applyStimulus(input int loc, input int val);
    bit legal;
    @(negedge clk);
    legal      = model_request(loc, val);
    submit     = 1'b1;
    update_loc = 4'(loc);
    update_val = 2'(val);
    wait_response("move_response");
    submit = 1'b0;
    model_settle(legal);
    repeat (3) @(negedge clk);
    checkOutput("after_move");
  endtask

  task automatic applyNewGame();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    checkOutput("new_game");
  endtask

  // Scoreboard monitor: every ack/nack pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ack || nack)) begin
      if (ack && nack) begin
        checks++;
        fails++;
        $display("[TB] FAIL ack_nack_exclusive: actual ack=1 nack=1 required one of them");
      end else if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_response: actual ack=%0d nack=%0d required none", ack, nack);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("resp_is_ack",     int'(ack),         int'(e.is_ack));
        check_val("resp_board",      int'(board_state), e.board);
        check_val("resp_move_count", int'(move_count),  e.count);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit legal;
    submit     = 1'b0;
    new_game   = 1'b0;
    update_loc = 4'd0;
    update_val = 2'd0;
    rst_n      = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 checkResetValues("power_on_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Legal centre move, then a run of illegal requests
    applyStimulus(4, 1);
    applyStimulus(4, 2);
    applyStimulus(9, 2);
    applyStimulus(0, 1);
    applyStimulus(0, 3);
    applyStimulus(0, 0);

    // X wins on the top row; later requests bounce off a frozen board
    applyNewGame();
    applyStimulus(0, 1);
    applyStimulus(3, 2);
    applyStimulus(1, 1);
    applyStimulus(4, 2);
    applyStimulus(2, 1);
    applyStimulus(5, 2);
    applyStimulus(5, 1);

    // Full board without a line
    applyNewGame();
    applyStimulus(0, 1);
    applyStimulus(1, 2);
    applyStimulus(2, 1);
    applyStimulus(4, 2);
    applyStimulus(3, 1);
    applyStimulus(5, 2);
    applyStimulus(7, 1);
    applyStimulus(6, 2);
    applyStimulus(8, 1);
    applyStimulus(8, 2);

    // Submit held for ten cycles earns exactly one answer
    applyNewGame();
    @(negedge clk);
    legal      = model_request(0, 1);
    submit     = 1'b1;
    update_loc = 4'd0;
    update_val = 2'd1;
    repeat (10) @(negedge clk);
    submit = 1'b0;
    model_settle(legal);
    repeat (3) @(negedge clk);
    check_val("held_submit_answered", exp_q.size(), 0);
    checkOutput("held_submit");
    applyStimulus(1, 2);

    // new_game on the same edge as a fresh submit: no request is taken
    @(negedge clk);
    submit     = 1'b1;
    new_game   = 1'b1;
    update_loc = 4'd2;
    update_val = 2'd1;
    @(negedge clk);
    new_game = 1'b0;
    repeat (4) @(negedge clk);
    submit = 1'b0;
    model_reset();
    @(negedge clk);
    checkOutput("new_game_with_submit");

    // new_game while the request is in RESP: aborted silently
    applyStimulus(4, 1);
    @(negedge clk);
    submit     = 1'b1;
    update_loc = 4'd0;
    update_val = 2'd2;
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    repeat (2) @(negedge clk);
    submit = 1'b0;
    model_reset();
    @(negedge clk);
    checkOutput("new_game_in_resp");

    // Reset in RESP with submit held; after release the held submit is new
    applyStimulus(0, 1);
    @(negedge clk);
    submit     = 1'b1;
    update_loc = 4'd4;
    update_val = 2'd1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetValues("reset_in_resp");
    model_reset();
    @(negedge clk);
    update_loc = 4'd4;
    update_val = 2'd1;
    rst_n = 1'b1;
    legal = model_request(4, 1);
    wait_response("resubmit_after_reset");
    submit = 1'b0;
    model_settle(legal);
    repeat (3) @(negedge clk);
    checkOutput("resubmit_after_reset");

    // Reset while the accepted move is being scored
    @(negedge clk);
    legal = model_request(5, 2);
    void'(exp_q.pop_back());
    submit     = 1'b1;
    update_loc = 4'd5;
    update_val = 2'd2;
    wait_response("eval_reset_move");
    check_val("eval_reset_ack_seen", int'(ack), int'(legal));
    #1 rst_n = 1'b0;
    #1 checkResetValues("reset_in_eval");
    submit = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("after_eval_reset");

    // Random games, mostly with the correct side's mark
    for (int g = 0; g < 4; g++) begin
      applyNewGame();
      for (int m = 0; m < 12; m++) begin
        int loc;
        int val;
        loc = int'($urandom_range(0, 9));
        if ($urandom_range(0, 3) != 0) val = (m_turn != 0) ? 2 : 1;
        else                           val = int'($urandom_range(0, 3));
        applyStimulus(loc, val);
      end
    end

    repeat (5) @(negedge clk);
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
